// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    // Reserved encodings fall through to a word access.
    function automatic lsu_size_e access_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            req_be;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/load_store_unit_aligner.sv
// Picks the addressed lane of a read word and sign/zero extends it.
module load_aligner
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    always_comb begin
        unique case (addr_lo)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sx = ~funct3[2];
        unique case (access_size(funct3))
            SZ_B:    result = {{24{sx & b[7]}}, b};
            SZ_H:    result = {{16{sx & h[15]}}, h};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store engine: valid/ready request, response capture, stall.
// Optional MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of issuing them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  mem_read_m_i,
    input  logic                  mem_write_m_i,
    input  logic [2:0]            funct3_m_i,
    input  logic [ADDR_WIDTH-1:0] alu_result_m_i,
    input  logic [31:0]           write_data_m_i,
    output logic [31:0]           read_data_m_o,
    output logic                  stall_m_o,
    output logic                  misaligned_o,
    load_store_unit_if.master     bus
);
    lsu_state_e state_q, state_d;
    lsu_size_e  size;
    logic [31:0] rdata_q;
    logic [31:0] load_val;
    logic [1:0]  lo;
    logic        op;
    logic        misalign;
    logic        mis_q;
    logic        req_valid;
    logic        stall;

    assign op   = mem_read_m_i | mem_write_m_i;
    assign size = access_size(funct3_m_i);
    assign lo   = alu_result_m_i[1:0];

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((size == SZ_H) && lo[0]) ||
                      ((size == SZ_W) && (lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op) begin
                    stall = 1'b1;
                    if (misalign) begin
                        state_d = DONE;
                    end else begin
                        req_valid = 1'b1;
                        if (bus.req_ready)
                            state_d = mem_read_m_i ? WAIT_RSP : DONE;
                    end
                end
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (bus.rsp_valid)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Keep the bus and pipeline quiet while reset is held.
        if (!reset_i) begin
            req_valid = 1'b0;
            stall     = 1'b0;
        end
    end

    assign bus.req_valid = req_valid;
    assign stall_m_o     = stall;
    assign bus.req_we    = mem_write_m_i & ~mem_read_m_i;
    assign bus.req_addr  = {alu_result_m_i[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        bus.req_be    = 4'b1111;
        bus.req_wdata = write_data_m_i;
        unique case (size)
            SZ_B: begin
                if (bus.req_we)
                    bus.req_be = 4'b0001 << lo;
                bus.req_wdata = {4{write_data_m_i[7:0]}};
            end
            SZ_H: begin
                if (bus.req_we)
                    bus.req_be = lo[1] ? 4'b1100 : 4'b0011;
                bus.req_wdata = {2{write_data_m_i[15:0]}};
            end
            default: ;
        endcase
    end

    load_aligner u_align (
        .rdata   (bus.rsp_rdata),
        .addr_lo (lo),
        .funct3  (funct3_m_i),
        .result  (load_val)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mis_q   <= (state_q == IDLE) && op && misalign;
            if ((state_q == WAIT_RSP) && bus.rsp_valid)
                rdata_q <= load_val;
            else if ((state_q == IDLE) && mem_read_m_i && misalign)
                rdata_q <= 32'd0;
        end
    end

    assign read_data_m_o = rdata_q;
    assign misaligned_o  = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rd;
    logic        stall;
    logic        mis;
    int n_chk = 0;
    int n_fail = 0;
    int hs = 0;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .mem_read_m_i   (mem_read),
        .mem_write_m_i  (mem_write),
        .funct3_m_i     (f3),
        .alu_result_m_i (addr),
        .write_data_m_i (wdata),
        .read_data_m_o  (rd),
        .stall_m_o      (stall),
        .misaligned_o   (mis),
        .bus            (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i)
        if (bus.req_valid && bus.req_ready) hs++;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] r);
        mem_read = 1'b1; f3 = f; addr = a; bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_rdata = r;
        step();
        bus.rsp_valid = 1'b0; mem_read = 1'b0;
        step();
    endtask

    task automatic test_reset;
        reset_i = 1'b0; mem_read = 1'b1;
        step(); step();
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_chk++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.req_valid); end
        n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rd); end
        n_chk++; if (mis !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", mis); end
        mem_read = 1'b0; reset_i = 1'b1;
        step();
    endtask

    task automatic test_lw;
        int stl = 0;
        mem_read = 1'b1; f3 = 3'b010; addr = 32'h100; bus.req_ready = 1'b1;
        #1;
        n_chk++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid: got %b want 1", bus.req_valid); end
        n_chk++; if (bus.req_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 100", bus.req_addr); end
        n_chk++; if (bus.req_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", bus.req_we); end
        n_chk++; if (bus.req_be !== 4'hf) begin n_fail++; $display("FAIL lw_be: got %b want 1111", bus.req_be); end
        if (stall) stl++;
        step();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hDEADBEEF;
        #1;
        n_chk++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL lw_wait_valid: got %b want 0", bus.req_valid); end
        if (stall) stl++;
        step();
        bus.rsp_valid = 1'b0;
        #1;
        if (stall) stl++;
        n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        n_chk++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL lw_done_valid: got %b want 0", bus.req_valid); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_done_stall: got %b want 0", stall); end
        mem_read = 1'b0;
        step();
        n_chk++; if (stl !== 2) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 2", stl); end
    endtask

    task automatic test_load_ext;
        logic [2:0]  vf [8] = '{3'b000, 3'b100, 3'b101, 3'b001,
                                3'b000, 3'b001, 3'b100, 3'b101};
        logic [31:0] va [8] = '{32'h103, 32'h103, 32'h102, 32'h102,
                                32'h100, 32'h100, 32'h101, 32'h100};
        logic [31:0] ve [8] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                                32'hFFFF80FF, 32'h0000007F, 32'hFFFFFF7F,
                                32'h000000FF, 32'h0000FF7F};
        for (int i = 0; i < 8; i++) begin
            do_load(vf[i], va[i], 32'h80FFFF7F);
            n_chk++;
            if (rd !== ve[i]) begin
                n_fail++;
                $display("FAIL load_ext_%0d: got %h want %h", i, rd, ve[i]);
            end
        end
    endtask

    task automatic test_sb_delayed;
        int stl = 0;
        mem_write = 1'b1; f3 = 3'b000; addr = 32'h201; wdata = 32'hAB;
        bus.req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid_%0d: got %b want 1", i, bus.req_valid); end
            n_chk++; if (bus.req_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be_%0d: got %b want 0010", i, bus.req_be); end
            n_chk++; if (bus.req_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_wdata_%0d: got %h want abababab", i, bus.req_wdata); end
            n_chk++; if (bus.req_addr !== 32'h200) begin n_fail++; $display("FAIL sb_addr_%0d: got %h want 200", i, bus.req_addr); end
            n_chk++; if (bus.req_we !== 1'b1) begin n_fail++; $display("FAIL sb_we_%0d: got %b want 1", i, bus.req_we); end
            if (stall) stl++;
            step();
        end
        bus.req_ready = 1'b1;
        #1;
        n_chk++; if (bus.req_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be_hs: got %b want 0010", bus.req_be); end
        if (stall) stl++;
        step();
        bus.req_ready = 1'b0;
        #1;
        if (stall) stl++;
        mem_write = 1'b0;
        step();
        n_chk++; if (stl !== 4) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d want 4", stl); end
    endtask

    task automatic test_store_lanes;
        logic [2:0]  vf [5] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b011};
        logic [31:0] va [5] = '{32'h200, 32'h202, 32'h200, 32'h300, 32'h104};
        logic [31:0] vd [5] = '{32'h000000AB, 32'h00001234, 32'h00005678,
                                32'hCAFEF00D, 32'h01020304};
        logic [3:0]  vb [5] = '{4'b0001, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
        logic [31:0] vw [5] = '{32'hABABABAB, 32'h12341234, 32'h56785678,
                                32'hCAFEF00D, 32'h01020304};
        for (int i = 0; i < 5; i++) begin
            mem_write = 1'b1; f3 = vf[i]; addr = va[i]; wdata = vd[i];
            bus.req_ready = 1'b1;
            #1;
            n_chk++; if (bus.req_be !== vb[i]) begin n_fail++; $display("FAIL st_be_%0d: got %b want %b", i, bus.req_be, vb[i]); end
            n_chk++; if (bus.req_wdata !== vw[i]) begin n_fail++; $display("FAIL st_wdata_%0d: got %h want %h", i, bus.req_wdata, vw[i]); end
            step();
            mem_write = 1'b0; bus.req_ready = 1'b0;
            step();
        end
    endtask

    task automatic test_misalign;
        int hs0 = hs;
        mem_read = 1'b1; f3 = 3'b010; addr = 32'h102; bus.req_ready = 1'b1;
        #1;
`ifdef MISALIGN_TRAP_EN
        n_chk++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", bus.req_valid); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mis_stall: got %b want 1", stall); end
        step();
        bus.req_ready = 1'b0; mem_read = 1'b0;
        #1;
        n_chk++; if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", mis); end
        n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", rd); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_done_stall: got %b want 0", stall); end
        step();
        n_chk++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", mis); end
        n_chk++; if (hs !== hs0) begin n_fail++; $display("FAIL mis_no_req: got %0d want %0d", hs - hs0, 0); end
`else
        n_chk++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b want 1", bus.req_valid); end
        n_chk++; if (bus.req_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr: got %h want 100", bus.req_addr); end
        step();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h11223344;
        step();
        bus.rsp_valid = 1'b0; mem_read = 1'b0;
        #1;
        n_chk++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL mis_rdata: got %h want 11223344", rd); end
        n_chk++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b want 0", mis); end
        step();
        n_chk++; if (hs - hs0 !== 1) begin n_fail++; $display("FAIL mis_one_req: got %0d want 1", hs - hs0); end
`endif
    endtask

    task automatic test_back_to_back;
        int hs0 = hs;
        mem_write = 1'b1; f3 = 3'b010; addr = 32'h300; wdata = 32'hCAFEF00D;
        bus.req_ready = 1'b1;
        #1;
        n_chk++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_valid: got %b want 1", bus.req_valid); end
        n_chk++; if (bus.req_we !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_we: got %b want 1", bus.req_we); end
        step();
        mem_write = 1'b0; mem_read = 1'b1; addr = 32'h304;
        #1;
        n_chk++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid: got %b want 0", bus.req_valid); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_stall: got %b want 0", stall); end
        step();
        n_chk++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_valid: got %b want 1", bus.req_valid); end
        n_chk++; if (bus.req_addr !== 32'h304) begin n_fail++; $display("FAIL b2b_lw_addr: got %h want 304", bus.req_addr); end
        n_chk++; if (bus.req_we !== 1'b0) begin n_fail++; $display("FAIL b2b_lw_we: got %b want 0", bus.req_we); end
        step();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h55AA55AA;
        step();
        bus.rsp_valid = 1'b0; mem_read = 1'b0;
        #1;
        n_chk++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL b2b_rdata: got %h want 55aa55aa", rd); end
        step();
        n_chk++; if (hs - hs0 !== 2) begin n_fail++; $display("FAIL b2b_req_count: got %0d want 2", hs - hs0); end
    endtask

    task automatic test_reset_mid;
        mem_read = 1'b1; f3 = 3'b010; addr = 32'h100; bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0; reset_i = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_stall: got %b want 0", stall); end
        step();
        reset_i = 1'b1; mem_read = 1'b0;
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h12345678;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b want 0", stall); end
        n_chk++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus.req_valid); end
        step();
        bus.rsp_valid = 1'b0;
        #1;
        n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rmid_rdata: got %h want 0", rd); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall2: got %b want 0", stall); end
        step();
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'd0;
        test_reset();
        test_lw();
        test_load_ext();
        test_sb_delayed();
        test_store_lanes();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
